// File: rtl/card_dealer_pkg.sv
// Shared types and constants for the card dealer controller.
// Holds the FSM state encoding, default sizing and requester identifiers.
package card_dealer_pkg;

  // Default sizing for a standard 52-card deck of 4-bit card values
  localparam int DECK_SIZE_DEF       = 52;
  localparam int ADDR_W_DEF          = 6;
  localparam int CARD_W_DEF          = 4;
  localparam int SHUFFLE_TIMEOUT_DEF = 1024;

  // Requester identifiers used for grants and the round-robin history
  localparam logic ID_PLAYER = 1'b0;
  localparam logic ID_DEALER = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SHUF_REQ  = 3'd1,
    ST_SHUF_WAIT = 3'd2,
    ST_READY     = 3'd3,
    ST_DEAL      = 3'd4,
    ST_EMPTY     = 3'd5,
    ST_ERROR     = 3'd6
  } state_e;

  // Fixed-priority pick: player wins whenever it asks; a lone dealer
  // request goes to the dealer. With no request the result is unused.
  function automatic logic fixed_winner(input logic req_player,
                                        input logic req_dealer);
    return (req_player || !req_dealer) ? ID_PLAYER : ID_DEALER;
  endfunction

endpackage

// File: rtl/card_dealer_arb.sv
// Two-requester arbiter for the shared deck read port.
// Build option: CARD_DEALER_RR_EN selects round-robin on ties; without it
// the player always wins ties and no history register exists.
module card_dealer_arb
  import card_dealer_pkg::*;
(
`ifdef CARD_DEALER_RR_EN
  input  logic clock,
  input  logic reset,
  input  logic grant_en,
`endif
  input  logic req_player,
  input  logic req_dealer,
  output logic grant_id
);

`ifdef CARD_DEALER_RR_EN
  // rr_last_q is 1 when the player received the most recent grant, so the
  // reset value of 0 means "dealer served last" and the player wins the
  // first tie.
  logic rr_last_q;
  logic rr_last_d;

  // Pick the winner, alternating on a tie, and record who was served
  always_comb begin
    grant_id  = fixed_winner(req_player, req_dealer);
    rr_last_d = rr_last_q;
    if (req_player && req_dealer) begin
      grant_id = rr_last_q ? ID_DEALER : ID_PLAYER;
    end
    if (grant_en) begin
      rr_last_d = (grant_id == ID_PLAYER);
    end
  end

  // Round-robin history register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_last_q <= 1'b0;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end
`else
  // Fixed priority: the player takes every tie
  always_comb begin
    grant_id = fixed_winner(req_player, req_dealer);
  end
`endif

endmodule

// File: rtl/card_dealer_ctrl.sv
// Card dealer sequencer: triggers one deck shuffle per game, then serves
// cards from a linear read pointer to the player and dealer, tracking the
// cards remaining and flagging deck exhaustion or a shuffle timeout.
// Build option: CARD_DEALER_RR_EN enables round-robin tie arbitration.
module card_dealer_ctrl
  import card_dealer_pkg::*;
#(
  parameter int DECK_SIZE       = DECK_SIZE_DEF,
  parameter int ADDR_W          = ADDR_W_DEF,
  parameter int CARD_W          = CARD_W_DEF,
  parameter int SHUFFLE_TIMEOUT = SHUFFLE_TIMEOUT_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_game,
  output logic              shuffle_start,
  input  logic              shuffle_done,
  output logic [ADDR_W-1:0] deck_addr,
  input  logic [CARD_W-1:0] deck_card,
  input  logic              req_player,
  input  logic              req_dealer,
  output logic [CARD_W-1:0] card_out,
  output logic              card_valid_player,
  output logic              card_valid_dealer,
  output logic [ADDR_W-1:0] cards_left,
  output logic              ready,
  output logic              deck_empty,
  output logic              shuffle_error
);

  // Wide enough to count 0 .. SHUFFLE_TIMEOUT-1
  localparam int TO_W = (SHUFFLE_TIMEOUT > 2) ? $clog2(SHUFFLE_TIMEOUT) : 1;

  localparam logic [ADDR_W-1:0] FULL_DECK  = ADDR_W'(DECK_SIZE);
  localparam logic [ADDR_W-1:0] LAST_CARD  = ADDR_W'(1);
  localparam logic [TO_W-1:0]   TO_LIMIT   = TO_W'(SHUFFLE_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] deck_addr_q, deck_addr_d;
  logic [ADDR_W-1:0] cards_left_q, cards_left_d;
  logic [CARD_W-1:0] card_out_q, card_out_d;
  logic              valid_player_q, valid_player_d;
  logic              valid_dealer_q, valid_dealer_d;
  logic [TO_W-1:0]   timeout_q, timeout_d;
  logic              grant_q, grant_d;

  logic any_req;
  logic arb_grant;
  logic grant_en;

  assign any_req  = req_player || req_dealer;
  assign grant_en = (state_q == ST_READY) && any_req;

  card_dealer_arb u_arb (
`ifdef CARD_DEALER_RR_EN
    .clock      (clock),
    .reset      (reset),
    .grant_en   (grant_en),
`endif
    .req_player (req_player),
    .req_dealer (req_dealer),
    .grant_id   (arb_grant)
  );

  // Next-state and datapath updates for the shuffle handshake and dealing
  always_comb begin
    state_d        = state_q;
    deck_addr_d    = deck_addr_q;
    cards_left_d   = cards_left_q;
    card_out_d     = card_out_q;
    valid_player_d = 1'b0;
    valid_dealer_d = 1'b0;
    timeout_d      = timeout_q;
    grant_d        = grant_q;

    case (state_q)
      ST_IDLE: begin
        if (start_game) begin
          state_d = ST_SHUF_REQ;
        end
      end

      ST_SHUF_REQ: begin
        timeout_d = '0;
        state_d   = ST_SHUF_WAIT;
      end

      ST_SHUF_WAIT: begin
        if (shuffle_done) begin
          deck_addr_d  = '0;
          cards_left_d = FULL_DECK;
          state_d      = ST_READY;
        end else if (timeout_q == TO_LIMIT) begin
          state_d = ST_ERROR;
        end else begin
          timeout_d = timeout_q + 1'b1;
        end
      end

      ST_READY: begin
        if (any_req) begin
          grant_d = arb_grant;
          state_d = ST_DEAL;
        end
      end

      ST_DEAL: begin
        card_out_d = deck_card;
        if (grant_q == ID_PLAYER) begin
          valid_player_d = 1'b1;
        end else begin
          valid_dealer_d = 1'b1;
        end
        cards_left_d = cards_left_q - 1'b1;
        if (cards_left_q == LAST_CARD) begin
          state_d = ST_EMPTY;
        end else begin
          deck_addr_d = deck_addr_q + 1'b1;
          state_d     = ST_READY;
        end
      end

      ST_EMPTY: begin
        state_d = ST_EMPTY;
      end

      ST_ERROR: begin
        state_d = ST_ERROR;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      deck_addr_q    <= '0;
      cards_left_q   <= '0;
      card_out_q     <= '0;
      valid_player_q <= 1'b0;
      valid_dealer_q <= 1'b0;
      timeout_q      <= '0;
      grant_q        <= ID_PLAYER;
    end else begin
      state_q        <= state_d;
      deck_addr_q    <= deck_addr_d;
      cards_left_q   <= cards_left_d;
      card_out_q     <= card_out_d;
      valid_player_q <= valid_player_d;
      valid_dealer_q <= valid_dealer_d;
      timeout_q      <= timeout_d;
      grant_q        <= grant_d;
    end
  end

  assign deck_addr         = deck_addr_q;
  assign cards_left        = cards_left_q;
  assign card_out          = card_out_q;
  assign card_valid_player = valid_player_q;
  assign card_valid_dealer = valid_dealer_q;
  assign shuffle_start     = (state_q == ST_SHUF_REQ);
  assign ready             = (state_q == ST_READY);
  assign deck_empty        = (state_q == ST_EMPTY);
  assign shuffle_error     = (state_q == ST_ERROR);

endmodule
